addsub_arbiter: RTL and testbench

- Shares one 3-bit two's-complement add/subtract datapath between two requesters.
- Each requester issues operations over a valid/ready request channel.
- The block round-robin arbitrates, latches operands, runs one operation through the registered datapath, and returns the result on a single tagged response channel.
- Sits between the switch/UI front-ends and the LED result display.

---
 rtl/addsub_pkg.sv | 7 +
 rtl/addsub_arbiter_if.sv | 16 +
 rtl/addsub_core.sv | 30 +++
 rtl/addsub_arbiter.sv | 82 ++++++++
 tb/tb_addsub_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state type, requester count and add/sub mode constants for addsub_arbiter
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam int NREQ = 2;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: two-requester valid/ready request channel plus tagged response channel; master = requesters/sink, slave = arbiter
interface addsub_arbiter_if #(parameter int WIDTH = 3);
  import addsub_pkg::*;
  logic [NREQ-1:0] req_valid, req_ready, req_sub;
  logic [NREQ*WIDTH-1:0] req_x, req_y;
  logic rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [WIDTH-1:0] rsp_sum;
  modport master (
    output req_valid, req_x, req_y, req_sub, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
  modport slave (
    input req_valid, req_x, req_y, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/addsub_core.sv
// addsub_core: combinational ripple add/subtract; in x, y, sub; out sum, cout, c_msb_in (carry into MSB), ovf (signed overflow)
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb_in,
  output logic             ovf
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] yb;
  assign yb = y ^ {WIDTH{sub}};
  always_comb begin
    c = '0;
    sum = '0;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = x[i] ^ yb[i] ^ c[i];
      c[i+1] = (x[i] & yb[i]) | (c[i] & (x[i] ^ yb[i]));
    end
    cout = c[WIDTH];
    c_msb_in = c[WIDTH-1];
    ovf = (sub == MODE_SUB) ? (x[WIDTH-1] != y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]) : c_msb_in ^ cout;
  end
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin shares one add/sub datapath between two requesters; ports clk, rst, bus (slave modport), busy, op_count; define ADDSUB_ARB_STICKY_OVF_EN to add clr_sticky/ovf_sticky
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  addsub_arbiter_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
`ifdef ADDSUB_ARB_STICKY_OVF_EN
  ,
  input  logic             clr_sticky,
  output logic [NREQ-1:0]  ovf_sticky
`endif
);
  state_t state, next_state;
  logic last_grant, grant, accept, rsp_hs, id_q, sub_q;
  logic [WIDTH-1:0] x_q, y_q, sum;
  logic cout, c_msb_in, ovf;
  addsub_core #(.WIDTH(WIDTH)) u_core (
    .x(x_q),
    .y(y_q),
    .sub(sub_q),
    .sum(sum),
    .cout(cout),
    .c_msb_in(c_msb_in),
    .ovf(ovf)
  );
  assign grant = &bus.req_valid ? ~last_grant : bus.req_valid[1];
  assign accept = state == IDLE && bus.req_valid[grant];
  assign bus.req_ready = accept ? NREQ'(1) << grant : '0;
  assign rsp_hs = state == RESP && bus.rsp_ready;
  assign busy = state != IDLE;
  always_comb begin
    next_state = state;
    next_state = state == IDLE ? (accept ? EXEC : IDLE) :
                 state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      x_q <= '0;
      y_q <= '0;
      sub_q <= 1'b0;
      id_q <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_sum <= '0;
      bus.rsp_cout <= 1'b0;
      bus.rsp_ovf <= 1'b0;
      op_count <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        x_q <= bus.req_x[int'(grant)*WIDTH +: WIDTH];
        y_q <= bus.req_y[int'(grant)*WIDTH +: WIDTH];
        sub_q <= bus.req_sub[grant];
        id_q <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id <= id_q;
        bus.rsp_sum <= sum;
        bus.rsp_cout <= cout;
        bus.rsp_ovf <= (sub_q == MODE_SUB) ? ovf : c_msb_in ^ cout;
      end
      if (rsp_hs) begin
        bus.rsp_valid <= 1'b0;
        op_count <= op_count + 1'b1;
      end
    end
  end
`ifdef ADDSUB_ARB_STICKY_OVF_EN
  always_ff @(posedge clk)
    ovf_sticky <= rst ? '0 : (clr_sticky ? '0 : ovf_sticky) | (rsp_hs && bus.rsp_ovf ? NREQ'(1) << bus.rsp_id : '0);
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed vectors with a response scoreboard checking id, sum, carry, overflow, latency and counters
module tb_addsub_arbiter;
  typedef struct {
    logic [2:0] x, y;
    logic s;
    logic [2:0] es;
    logic ec, eo;
  } op_t;
  typedef struct {
    int id;
    logic [2:0] es;
    logic ec, eo;
    int cyc;
  } exp_t;
  logic clk = 0, rst = 1, rr = 1;
  logic [1:0] rv = 0, rs = 0;
  logic [2:0] x0 = 0, x1 = 0, y0 = 0, y1 = 0;
  logic prev_v = 0, both_rdy = 0;
  logic busy;
  logic [7:0] op_count;
  int cyc = 0, checks = 0, errors = 0, exp_cnt = 0, rise = 0;
  op_t q0[$], q1[$];
  exp_t sb[$];
  int grants[$];
`ifdef ADDSUB_ARB_STICKY_OVF_EN
  logic clr_sticky = 0;
  logic [1:0] ovf_sticky;
`endif
  addsub_arbiter_if #(.WIDTH(3)) bus();
  assign bus.req_valid = rv;
  assign bus.req_x = {x1, x0};
  assign bus.req_y = {y1, y0};
  assign bus.req_sub = rs;
  assign bus.rsp_ready = rr;
  addsub_arbiter #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .op_count(op_count)
`ifdef ADDSUB_ARB_STICKY_OVF_EN
    ,
    .clr_sticky(clr_sticky),
    .ovf_sticky(ovf_sticky)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic push_op(input int r, input int x, input int y, input int s, input int es, input int ec, input int eo);
    op_t o;
    o = '{3'(x), 3'(y), 1'(s), 3'(es), 1'(ec), 1'(eo)};
    if (r == 0) q0.push_back(o);
    else q1.push_back(o);
  endtask
  task automatic run_ops();
    int lim;
    lim = 10 * (q0.size() + q1.size()) + 20;
    while (q0.size() + q1.size() > 0 && lim > 0) begin
      @(posedge clk);
      #1;
      rv = {q1.size() > 0, q0.size() > 0};
      if (q0.size() > 0) begin x0 = q0[0].x; y0 = q0[0].y; rs[0] = q0[0].s; end
      if (q1.size() > 0) begin x1 = q1[0].x; y1 = q1[0].y; rs[1] = q1[0].s; end
      @(negedge clk);
      if (bus.req_ready[0] && q0.size() > 0) begin
        sb.push_back('{0, q0[0].es, q0[0].ec, q0[0].eo, cyc + 2});
        grants.push_back(0);
        void'(q0.pop_front());
      end
      if (bus.req_ready[1] && q1.size() > 0) begin
        sb.push_back('{1, q1[0].es, q1[0].ec, q1[0].eo, cyc + 2});
        grants.push_back(1);
        void'(q1.pop_front());
      end
      lim--;
    end
    @(posedge clk);
    #1 rv = '0;
    if (q0.size() + q1.size() != 0) chk("run_timeout", q0.size() + q1.size(), 0);
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((sb.size() != 0 || busy) && k < 60);
    if (sb.size() != 0 || busy) chk("idle_timeout", sb.size() + int'(busy), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.req_ready == 2'b11) both_rdy = 1;
    if (bus.rsp_valid && !prev_v) rise = cyc;
    prev_v = bus.rsp_valid;
    if (bus.rsp_valid && bus.rsp_ready && !rst) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_id", int'(bus.rsp_id), e.id);
        chk("rsp_sum", int'(bus.rsp_sum), int'(e.es));
        chk("rsp_cout", int'(bus.rsp_cout), int'(e.ec));
        chk("rsp_ovf", int'(bus.rsp_ovf), int'(e.eo));
        chk("latency", rise, e.cyc);
        exp_cnt++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt0, bad;
    logic [5:0] snap;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_sum", int'(bus.rsp_sum), 0);
    chk("rst_rsp_cout", int'(bus.rsp_cout), 0);
    chk("rst_rsp_ovf", int'(bus.rsp_ovf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_op_count", int'(op_count), 0);
    push_op(0, 3, 2, 0, 5, 0, 1);
    run_ops();
    wait_idle();
    chk("t1_count", int'(op_count), 1);
    push_op(1, 2, 3, 1, 7, 0, 0);
    push_op(1, 4, 1, 1, 3, 1, 1);
    run_ops();
    wait_idle();
    chk("t2_count", int'(op_count), 3);
    grants.delete();
    push_op(0, 1, 1, 0, 2, 0, 0);
    push_op(0, 3, 3, 1, 0, 1, 0);
    push_op(1, 2, 1, 1, 1, 1, 0);
    push_op(1, 5, 6, 0, 3, 1, 1);
    run_ops();
    wait_idle();
    chk("t3_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) chk("t3_grant_order", grants[i], i % 2);
    chk("t3_count", int'(op_count), exp_cnt % 256);
    rr = 0;
    push_op(0, 7, 1, 0, 0, 1, 0);
    run_ops();
    rv[1] = 1;
    x1 = 3'd1;
    y1 = 3'd2;
    rs[1] = 0;
    for (int k = 0; k < 10 && !bus.rsp_valid; k++) @(negedge clk);
    chk("t4_rsp_valid", int'(bus.rsp_valid), 1);
    snap = {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf};
    cnt0 = int'(op_count);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf} != snap || bus.req_ready != 2'b00 || !bus.rsp_valid) bad++;
    end
    chk("t4_hold", bad, 0);
    @(posedge clk);
    #1 rr = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_count", int'(op_count), (cnt0 + 1) % 256);
    chk("t4_next_accept", int'(bus.req_ready), 2);
    if (bus.req_ready[1]) sb.push_back('{1, 3'd3, 1'b0, 1'b0, cyc + 2});
    @(posedge clk);
    #1 rv = '0;
    wait_idle();
    @(posedge clk);
    #1;
    rv[1] = 1;
    x1 = 3'd3;
    y1 = 3'd3;
    rs[1] = 0;
    @(negedge clk);
    chk("t5_accept", int'(bus.req_ready), 2);
    @(posedge clk);
    #1 rv = '0;
    @(negedge clk);
    chk("t5_exec_busy", int'(busy), 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    exp_cnt = 0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_rsp_valid", int'(bus.rsp_valid), 0);
    chk("t5_op_count", int'(op_count), 0);
    chk("t5_rsp_sum", int'(bus.rsp_sum), 0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    chk("t5_no_rsp", bad, 0);
    grants.delete();
    push_op(0, 1, 2, 1, 7, 0, 0);
    push_op(1, 6, 3, 0, 1, 1, 0);
    run_ops();
    wait_idle();
    chk("t5_first_grant", grants.size() > 0 ? grants[0] : -1, 0);
    for (int k = 2; k < 255; k++) push_op(0, 1, 1, 0, 2, 0, 0);
    run_ops();
    wait_idle();
    chk("t5_count_255", int'(op_count), 255);
    push_op(1, 6, 1, 1, 5, 1, 0);
    run_ops();
    wait_idle();
    chk("t5_wrap", int'(op_count), 0);
`ifdef ADDSUB_ARB_STICKY_OVF_EN
    push_op(1, 3, 2, 0, 5, 0, 1);
    run_ops();
    wait_idle();
    chk("t6_set", int'(ovf_sticky), 2);
    @(posedge clk);
    #1 clr_sticky = 1;
    @(posedge clk);
    #1 clr_sticky = 0;
    @(negedge clk);
    chk("t6_clr", int'(ovf_sticky), 0);
    rr = 0;
    push_op(1, 3, 2, 0, 5, 0, 1);
    run_ops();
    for (int k = 0; k < 10 && !bus.rsp_valid; k++) @(negedge clk);
    @(posedge clk);
    #1;
    rr = 1;
    clr_sticky = 1;
    @(posedge clk);
    #1 clr_sticky = 0;
    @(negedge clk);
    chk("t6_set_wins", int'(ovf_sticky), 2);
    wait_idle();
`endif
    chk("never_both_ready", int'(both_rdy), 0);
    chk("final_count", int'(op_count), exp_cnt % 256);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
